// File: rtl/tick_source.sv
// Programmable tick generator: divides clock by (BASE_PERIOD >> speed), with run/pause/step/halt control.
// First tick lands period cycles after go; no backpressure, tick is a fire-and-forget registered pulse.
module tick_source #(
    parameter int BASE_PERIOD = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       pause,
    input  logic       step,
    input  logic       halt,
    input  logic [1:0] speed,
    output logic       tick,
    output logic       running,
    output logic [7:0] tick_total
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_PERIOD);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload;
    logic             cnt_zero;

    assign reload   = (BASE >> speed) - CNT_W'(1);
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tick       <= 1'b0;
            running    <= 1'b0;
            tick_total <= 8'd0;
        end else begin
            tick <= 1'b0;
            if (halt) begin
                state   <= IDLE;
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go) begin
                            state      <= RUN;
                            running    <= 1'b1;
                            cnt        <= reload;
                            tick_total <= 8'd0;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (cnt_zero) begin
                            tick       <= 1'b1;
                            cnt        <= reload;
                            tick_total <= tick_total + 8'd1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    PAUSE: begin
                        // The pausing edge held cnt, so the resuming edge counts to keep the phase.
                        if (pause) begin
                            state <= PAUSE;
                        end else if (go) begin
                            state   <= RUN;
                            running <= 1'b1;
                            if (cnt_zero) begin
                                tick       <= 1'b1;
                                cnt        <= reload;
                                tick_total <= tick_total + 8'd1;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end else if (step) begin
                            state   <= STEP;
                            running <= 1'b1;
                        end
                    end
                    STEP: begin
                        state      <= PAUSE;
                        running    <= 1'b0;
                        tick       <= 1'b1;
                        tick_total <= tick_total + 8'd1;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_source.sv
// Directed bench for tick_source with BASE_PERIOD = 8.
module tb_tick_source;

    logic       clock;
    logic       reset;
    logic       go;
    logic       pause;
    logic       step;
    logic       halt;
    logic [1:0] speed;
    logic       tick;
    logic       running;
    logic [7:0] tick_total;

    int total  = 0;
    int passed = 0;

    tick_source #(.BASE_PERIOD(8), .CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
        .pause      (pause),
        .step       (step),
        .halt       (halt),
        .speed      (speed),
        .tick       (tick),
        .running    (running),
        .tick_total (tick_total)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; pause = 1'b0; step = 1'b0; halt = 1'b0; speed = 2'd0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_total", 32'(tick_total), 0);
        chk("rst_cnt", 32'(dut.cnt), 0);

        // Steady run at speed 0: ticks 8, 16, 24 edges after the go edge.
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        chk("go_running", 32'(running), 1);
        chk("go_cnt", 32'(dut.cnt), 7);
        for (int k = 1; k <= 24; k++) begin
            cyc(1);
            chk($sformatf("run_tick_k%0d", k), 32'(tick), (k % 8 == 0) ? 1 : 0);
            if (k % 8 == 0) chk($sformatf("run_total_k%0d", k), 32'(tick_total), 32'(k / 8));
        end
        chk("run_running", 32'(running), 1);

        // Speed change mid-period: the 8-cycle period finishes, then period 1.
        for (int k = 25; k <= 40; k++) begin
            cyc(1);
            chk($sformatf("spd_tick_k%0d", k), 32'(tick), (k >= 32) ? 1 : 0);
            if (k == 27) speed = 2'd3;
        end
        chk("spd_total", 32'(tick_total), 12);
        speed = 2'd0;
        cyc(1);
        chk("spd_back_tick", 32'(tick), 1);
        chk("spd_back_total", 32'(tick_total), 13);
        chk("spd_back_cnt", 32'(dut.cnt), 7);

        // Pause 3 cycles after a tick, for 10 cycles; next tick 18 wall cycles after previous.
        cyc(2);
        chk("pre_pause_cnt", 32'(dut.cnt), 5);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk($sformatf("pause_tick_%0d", i), 32'(tick), 0);
            chk($sformatf("pause_run_%0d", i), 32'(running), 0);
        end
        chk("pause_cnt_frozen", 32'(dut.cnt), 5);
        pause = 1'b0;
        go = 1'b1;
        for (int e = 13; e <= 18; e++) begin
            cyc(1);
            go = 1'b0;
            chk($sformatf("resume_tick_e%0d", e), 32'(tick), (e == 18) ? 1 : 0);
            chk($sformatf("resume_running_e%0d", e), 32'(running), 1);
        end
        chk("resume_total", 32'(tick_total), 14);

        // Single step from PAUSE.
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("step_pre_cnt", 32'(dut.cnt), 7);
        chk("step_pre_running", 32'(running), 0);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step_s0_tick", 32'(tick), 0);
        chk("step_s0_running", 32'(running), 1);
        cyc(1);
        chk("step_s1_tick", 32'(tick), 1);
        chk("step_s1_running", 32'(running), 0);
        chk("step_s1_cnt", 32'(dut.cnt), 7);
        chk("step_s1_total", 32'(tick_total), 15);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk($sformatf("step_after_%0d", i), 32'(tick), 0);
        end
        step = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk($sformatf("step_hold_%0d", i), 32'(tick), (i % 2 == 1) ? 1 : 0);
        end
        step = 1'b0;
        cyc(1);
        chk("step_hold_end_tick", 32'(tick), 0);
        chk("step_hold_total", 32'(tick_total), 18);
        chk("step_hold_cnt", 32'(dut.cnt), 7);

        // Halt during RUN.
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        chk("halt_pre_cnt", 32'(dut.cnt), 6);
        cyc(2);
        halt = 1'b1;
        cyc(1);
        halt = 1'b0;
        chk("halt_running", 32'(running), 0);
        chk("halt_tick", 32'(tick), 0);
        chk("halt_cnt", 32'(dut.cnt), 0);
        chk("halt_total", 32'(tick_total), 18);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk($sformatf("idle_tick_%0d", i), 32'(tick), 0);
        end
        chk("idle_total", 32'(tick_total), 18);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        chk("restart_total", 32'(tick_total), 0);
        chk("restart_cnt", 32'(dut.cnt), 7);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("restart_tick_k%0d", k), 32'(tick), (k == 8) ? 1 : 0);
        end
        chk("restart_total_1", 32'(tick_total), 1);

        // Wrap at speed 3, then asynchronous reset.
        halt = 1'b1;
        cyc(1);
        halt = 1'b0;
        speed = 2'd3;
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        chk("wrap_start_cnt", 32'(dut.cnt), 0);
        cyc(255);
        chk("wrap_255", 32'(tick_total), 255);
        chk("wrap_255_tick", 32'(tick), 1);
        cyc(1);
        chk("wrap_0", 32'(tick_total), 0);
        chk("wrap_0_tick", 32'(tick), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tick", 32'(tick), 0);
        chk("arst_running", 32'(running), 0);
        chk("arst_total", 32'(tick_total), 0);
        cyc(1);
        reset = 1'b0;
        cyc(3);
        chk("post_rst_running", 32'(running), 0);
        chk("post_rst_tick", 32'(tick), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
